// File: rtl/bcd2_display_drv_pkg.sv
// ---------------------------------------------------------------------------
// bcd2_display_pkg
// Shared types and constants for the two-digit multiplexed BCD display
// driver: digit-select state type, active-low segment patterns
// ({g,f,e,d,c,b,a}) and active-low digit-enable patterns.
// No ports (package).
// ---------------------------------------------------------------------------
package bcd2_display_pkg;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } digit_sel_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_NONE = 2'b11;

    function automatic logic is_bcd(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd2_display_drv_if.sv
// ---------------------------------------------------------------------------
// bcd2_display_drv_if
// Bundles the digit-load strobe/data and the display outputs.
//   load  : capture strobe for ones/tens
//   ones  : BCD units digit
//   tens  : BCD tens digit
//   seg   : active-low segments {g,f,e,d,c,b,a}
//   an    : active-low digit enables (an[0] units, an[1] tens)
//   err   : sticky invalid-digit flag
// master = digit source, slave = display driver.
// ---------------------------------------------------------------------------
interface bcd2_display_drv_if;

    logic       load;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    modport master (
        output load, ones, tens,
        input  seg, an, err
    );

    modport slave (
        input  load, ones, tens,
        output seg, an, err
    );

endinterface

// File: rtl/bcd2_display_drv_bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD to active-low 7-segment decoder. Codes above 9 blank.
//   bcd_i : 4-bit BCD digit
//   seg_o : segments {g,f,e,d,c,b,a}, active low
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import bcd2_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd2_display_drv.sv
// ---------------------------------------------------------------------------
// bcd2_display_drv
// Two-digit multiplexed BCD display driver. Valid loads are captured into
// shadow registers; a prescaler selects which digit slot is shown, and the
// segment/enable outputs are registered from the current slot and shadows.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd2_display_drv_if.slave (load/ones/tens in, seg/an/err out)
// Parameters:
//   REFRESH_DIV : clock cycles per digit slot (2..2^20)
// Build option:
//   BCD2_DISPLAY_DRV_LZB_EN : blank the tens digit (seg and an) when it is 0
//
// state | meaning
// ------+------------------------------------------
// ONES  | units digit slot, an = 2'b10
// TENS  | tens digit slot,  an = 2'b01 (2'b11 when blanked)
// ---------------------------------------------------------------------------
module bcd2_display_drv
    import bcd2_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
)(
    input  logic                  clk,
    input  logic                  rst_n,
    bcd2_display_drv_if.slave     bus
);

    localparam int unsigned    CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_sel_e       state_q, state_d;
    logic [3:0]       sh_ones_q, sh_ones_d;
    logic [3:0]       sh_tens_q, sh_tens_d;
    logic             err_q, err_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;

    logic             tc;
    logic [3:0]       dec_in;
    logic [6:0]       dec_out;

    bcd_to_7seg u_dec (
        .bcd_i (dec_in),
        .seg_o (dec_out)
    );

    always_comb begin
        tc        = (cnt_q == CNT_TC);
        cnt_d     = tc ? '0 : cnt_q + CNT_W'(1);

        state_d   = state_q;
        if (tc) begin
            state_d = (state_q == ONES) ? TENS : ONES;
        end

        // A bad digit rejects the whole load so the display never shows a
        // half-updated pair.
        sh_ones_d = sh_ones_q;
        sh_tens_d = sh_tens_q;
        err_d     = err_q;
        if (bus.load) begin
            if (is_bcd(bus.ones) && is_bcd(bus.tens)) begin
                sh_ones_d = bus.ones;
                sh_tens_d = bus.tens;
                err_d     = 1'b0;
            end else begin
                err_d     = 1'b1;
            end
        end

        // Outputs follow the registered slot and shadows, one cycle behind.
        dec_in = (state_q == ONES) ? sh_ones_q : sh_tens_q;
        seg_d  = dec_out;
        an_d   = (state_q == ONES) ? AN_ONES : AN_TENS;
`ifdef BCD2_DISPLAY_DRV_LZB_EN
        if ((state_q == TENS) && (sh_tens_q == 4'd0)) begin
            seg_d = SEG_BLANK;
            an_d  = AN_NONE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            state_q   <= ONES;
            sh_ones_q <= 4'd0;
            sh_tens_q <= 4'd0;
            err_q     <= 1'b0;
            seg_q     <= SEG_0;
            an_q      <= AN_ONES;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            sh_ones_q <= sh_ones_d;
            sh_tens_q <= sh_tens_d;
            err_q     <= err_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.err = err_q;

endmodule

// File: tb/tb_bcd2_display_drv.sv
// ---------------------------------------------------------------------------
// tb_bcd2_display_drv
// Directed bench for bcd2_display_drv with REFRESH_DIV=4. A per-cycle
// vector table covers refresh, loads, invalid loads and both slots; short
// hand-written sequences cover load-on-terminal-count and mid-slot reset.
// ---------------------------------------------------------------------------
module tb_bcd2_display_drv;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [1:0] A_ONES = 2'b10;
    localparam logic [1:0] A_TENS = 2'b01;
`ifdef BCD2_DISPLAY_DRV_LZB_EN
    localparam logic [6:0] T0_SEG = 7'b1111111;
    localparam logic [1:0] T0_AN  = 2'b11;
`else
    localparam logic [6:0] T0_SEG = 7'b1000000;
    localparam logic [1:0] T0_AN  = 2'b01;
`endif

    typedef struct {
        logic       ld;
        logic [3:0] o;
        logic [3:0] t;
        logic [6:0] seg;
        logic [1:0] an;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    bcd2_display_drv_if dut_if();

    bcd2_display_drv #(.REFRESH_DIV(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_vec++;
        if (dut_if.an == 2'b00) begin
            n_err++;
            $display("FAIL an_never_00 @%0t: an=%b, must not be 00", $time, dut_if.an);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic add(input logic ld, input logic [3:0] o, input logic [3:0] t,
                       input logic [6:0] seg, input logic [1:0] an, input logic err,
                       input int reps);
        vec_t v;
        v.ld = ld; v.o = o; v.t = t; v.seg = seg; v.an = an; v.err = err;
        for (int k = 0; k < reps; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [6:0] es,
                         input logic [1:0] ea, input logic ee);
        n_vec++;
        if ({dut_if.seg, dut_if.an, dut_if.err} !== {es, ea, ee}) begin
            n_err++;
            $display("FAIL %s: got seg=%b an=%b err=%b, want seg=%b an=%b err=%b",
                     name, dut_if.seg, dut_if.an, dut_if.err, es, ea, ee);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, return at
    // the next falling edge where outputs are stable.
    task automatic step(input logic ld, input logic [3:0] o, input logic [3:0] t);
        dut_if.load = ld;
        dut_if.ones = o;
        dut_if.tens = t;
        @(posedge clk);
        @(negedge clk);
        dut_if.load = 1'b0;
    endtask

    // Called at a falling edge: asserts reset mid-cycle, checks the async
    // reset values before any clock edge, releases at the next falling edge.
    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1 check(name, S0, A_ONES, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        dut_if.load = 1'b0;
        dut_if.ones = 4'd0;
        dut_if.tens = 4'd0;

        // expected outputs after rising edge n (n counted from reset release)
        add(0, 0, 0, S0, A_ONES, 0, 4);        // 1-4
        add(0, 0, 0, T0_SEG, T0_AN, 0, 4);     // 5-8
        add(0, 0, 0, S0, A_ONES, 0, 2);        // 9-10
        add(1, 7, 4, S0, A_ONES, 0, 1);        // 11 load 7/4
        add(0, 0, 0, S7, A_ONES, 0, 1);        // 12
        add(0, 0, 0, S4, A_TENS, 0, 4);        // 13-16
        add(0, 0, 0, S7, A_ONES, 0, 1);        // 17
        add(1, 4'hA, 3, S7, A_ONES, 1, 1);     // 18 invalid load
        add(0, 0, 0, S7, A_ONES, 1, 2);        // 19-20
        add(0, 0, 0, S4, A_TENS, 1, 4);        // 21-24
        add(0, 0, 0, S7, A_ONES, 1, 1);        // 25
        add(1, 2, 5, S7, A_ONES, 0, 1);        // 26 valid load 2/5
        add(0, 0, 0, S2, A_ONES, 0, 2);        // 27-28
        add(0, 0, 0, S5, A_TENS, 0, 4);        // 29-32
        add(0, 0, 0, S2, A_ONES, 0, 1);        // 33
        add(1, 1, 3, S2, A_ONES, 0, 1);        // 34 load 1/3
        add(0, 0, 0, S1, A_ONES, 0, 2);        // 35-36
        add(0, 0, 0, S3, A_TENS, 0, 1);        // 37
        add(1, 6, 6, S3, A_TENS, 0, 1);        // 38 load 6/6 in tens slot
        add(0, 0, 0, S6, A_TENS, 0, 2);        // 39-40
        add(0, 0, 0, S6, A_ONES, 0, 1);        // 41

        #2 rst_n = 1'b0;
        #1 check("reset_state", S0, A_ONES, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].o, vecs[i].t);
            check($sformatf("vec%0d", i + 1), vecs[i].seg, vecs[i].an, vecs[i].err);
        end

        // load 9/9 on the edge where the prescaler wraps
        do_reset("rst_a");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check("a_pre", S0, A_ONES, 1'b0);
        end
        step(1, 9, 9);
        check("a_load_tc", S0, A_ONES, 1'b0);
        step(0, 0, 0);
        check("a_tens_new", S9, A_TENS, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check("a_tens_hold", S9, A_TENS, 1'b0);
        end
        step(0, 0, 0);
        check("a_ones_new", S9, A_ONES, 1'b0);

        // load 8/8, set err, then reset mid-slot
        do_reset("rst_b");
        step(0, 0, 0);
        check("b_c1", S0, A_ONES, 1'b0);
        step(1, 8, 8);
        check("b_load", S0, A_ONES, 1'b0);
        step(1, 4'hB, 8);
        check("b_bad", S8, A_ONES, 1'b1);
        do_reset("b_mid_rst");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            check("b_after_ones", S0, A_ONES, 1'b0);
        end
        step(0, 0, 0);
        check("b_after_tens", T0_SEG, T0_AN, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd2_display_drv.md
BCD2_DISPLAY_DRV -- requirements
Module: bcd2_display_drv

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port load, input, 1, capture strobe for ones/tens, sampled on the rising edge of clk.
REQ-005 The block SHALL have port ones, input, 4, BCD units digit.
REQ-006 The block SHALL have port tens, input, 4, BCD tens digit.
REQ-007 The block SHALL have port seg, output, 7, active-low segments, bit order {g,f,e,d,c,b,a}, registered.
REQ-008 The block SHALL have port an, output, 2, active-low digit enables, an[0] for the units digit and an[1] for the tens digit, registered.
REQ-009 The block SHALL have port err, output, 1, sticky invalid-digit flag, registered.

Function
REQ-010 When load=1 and both ones and tens are at most 9, the block SHALL copy them into shadow registers sh_ones/sh_tens at that edge and clear err.
REQ-011 When load=1 and either digit exceeds 9, the block SHALL leave the shadow registers unchanged and set err=1 at that edge.
REQ-012 err SHALL hold its value until the next valid load or reset.
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the terminal count is REFRESH_DIV-1.
REQ-014 The digit-select FSM SHALL have two states, ONES and TENS, and SHALL toggle ONES<->TENS on each terminal count; there are no other transitions.
REQ-015 seg and an SHALL be registered every cycle from the current FSM state and shadow values, giving 1 cycle of latency from a state or shadow change.
REQ-016 In state ONES the block SHALL drive an=2'b10 and seg=decode(sh_ones); in state TENS it SHALL drive an=2'b01 and seg=decode(sh_tens).
REQ-017 Decode values SHALL be: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
REQ-018 A load coincident with a terminal count SHALL take effect in both the shadow registers and the FSM at the same edge, so the new slot shows the new value one cycle later.
REQ-019 The latency from a load edge to the new value appearing on seg SHALL be exactly 1 cycle when the affected digit's slot is active.
REQ-020 an SHALL never be 2'b00 at any cycle.

Reset
REQ-021 While rst_n=0 the block SHALL asynchronously force: sh_ones=0, sh_tens=0, prescaler=0, state=ONES, seg=7'b1000000, an=2'b10, err=0.
REQ-022 After rst_n deasserts, the first terminal count SHALL occur REFRESH_DIV cycles later.
REQ-023 A reset asserted mid-slot SHALL discard all prescaler and shadow state; nothing is preserved.

Configuration
REQ-024 When macro BCD2_DISPLAY_DRV_LZB_EN is defined, in state TENS with sh_tens=0 the block SHALL drive seg=7'b1111111 and an=2'b11, blanking the leading zero.
REQ-025 When BCD2_DISPLAY_DRV_LZB_EN is not defined, the block SHALL always show the tens digit, including 0; units-digit behaviour is identical in both builds.

Structure
REQ-026 Package bcd2_display_pkg SHALL hold the digit-select state typedef (ONES/TENS), the segment constants SEG_0..SEG_9 and SEG_BLANK, and the an constants AN_ONES, AN_TENS and AN_NONE.
REQ-027 Sub-module bcd_to_7seg SHALL be a purely combinational 4-bit to 7-bit decoder that returns SEG_BLANK for inputs above 9; the block instantiates it once, with its input muxed by state.

Verification (REFRESH_DIV=4)
REQ-028 Reset release, no load -> an alternates 10/01 every 4 cycles; seg=7'b1000000 in both slots (tens slot blank, an=11, with LZB_EN).
REQ-029 load with ones=7, tens=4 during the ONES slot -> seg=7'b1111000 1 cycle later; the next TENS slot shows 7'b0011001.
REQ-030 load with ones=4'hA, tens=3 -> err=1 and the display is unchanged; a subsequent valid load with ones=2, tens=5 -> err=0 and digits 2/5 are shown.
REQ-031 load coincident with the terminal count, ones=9, tens=9 -> the next cycle shows an=01 and seg=7'b0010000.
REQ-032 rst_n pulsed low mid-slot after a load of 8/8 -> outputs immediately return to seg=7'b1000000, an=10, err=0.
REQ-033 Every test SHALL check continuously that an is never 2'b00.
